// File: rtl/gray_conv_arbiter_if.sv
// ---------------------------------------------------------------------------
// gray_conv_arbiter_if
// Bundles the two requester channels, the response channel and the busy flag
// of the shared binary<->Gray converter.
//   req0_*/req1_* : valid/ready handshake plus mode (0=b2g, 1=g2b) and operand
//   rsp_*         : valid/ready handshake plus owning requester id and result
//   busy          : converter is not idle
// Modports: slave = the converter, master = requesters/consumer side.
// ---------------------------------------------------------------------------
interface gray_conv_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic             req0_mode;
    logic [WIDTH-1:0] req0_data;
    logic             req1_valid;
    logic             req1_ready;
    logic             req1_mode;
    logic [WIDTH-1:0] req1_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    modport slave (
        input  req0_valid, req0_mode, req0_data,
        input  req1_valid, req1_mode, req1_data,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req0_valid, req0_mode, req0_data,
        output req1_valid, req1_mode, req1_data,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/gray_conv_arbiter.sv
// ---------------------------------------------------------------------------
// gray_conv_arbiter
// One binary<->Gray conversion engine shared by two requesters through a
// round-robin arbiter. Binary->Gray takes one cycle; Gray->binary resolves one
// bit per cycle, MSB first. The result is returned tagged with the requester id
// and held until the consumer takes it.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : gray_conv_arbiter_if.slave (request, response and busy signals)
// ---------------------------------------------------------------------------
module gray_conv_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gray_conv_arbiter_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B2G  = 2'd1,
        G2B  = 2'd2,
        RESP = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   op_q, op_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               id_q, id_d;
    logic               last_grant_q, last_grant_d;

    logic               grant0;
    logic               grant1;
    logic               accept;
    logic               acc_mode;
    logic [WIDTH-1:0]   acc_data;
    logic [WIDTH-1:0]   g2b_step;

    // Round-robin: a lone requester always wins; on contention the one that
    // was not granted last time wins.
    assign grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
    assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);

    assign bus.req0_ready = (state_q == IDLE) & grant0;
    assign bus.req1_ready = (state_q == IDLE) & grant1;
    assign accept         = bus.req0_ready | bus.req1_ready;
    assign acc_mode       = grant1 ? bus.req1_mode : bus.req0_mode;
    assign acc_data       = grant1 ? bus.req1_data : bus.req0_data;

    // One Gray->binary step: only the bit selected by cnt_q is resolved, from
    // the already-resolved bit above it; every other bit is kept.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_g2b_bit
            assign g2b_step[gi] = (cnt_q == CNT_W'(gi)) ? (res_q[gi+1] ^ op_q[gi])
                                                        : res_q[gi];
        end
    endgenerate
    assign g2b_step[WIDTH-1] = res_q[WIDTH-1];

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        res_d        = res_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d         = acc_data;
                    id_d         = grant1;
                    last_grant_d = grant1;
                    if (acc_mode) begin
                        // MSB of a Gray code equals the binary MSB.
                        res_d   = {acc_data[WIDTH-1], {(WIDTH-1){1'b0}}};
                        cnt_d   = CNT_W'(WIDTH - 2);
                        state_d = G2B;
                    end else begin
                        state_d = B2G;
                    end
                end
            end
            B2G: begin
                res_d   = op_q ^ (op_q >> 1);
                state_d = RESP;
            end
            G2B: begin
                res_d = g2b_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            res_q        <= '0;
            cnt_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;   // requester 0 wins the first contention
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            res_q        <= res_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = res_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gray_conv_arbiter
// Directed and randomized transactions against a reference model built from
// the Gray-code definitions (prefix XOR) and a round-robin grant tracker.
// ---------------------------------------------------------------------------
module tb_gray_conv_arbiter;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    bit   last;          // model of the last granted requester

    gray_conv_arbiter_if #(.WIDTH(W)) bus ();

    gray_conv_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_b2g(input logic [W-1:0] x);
        return x ^ (x >> 1);
    endfunction

    // binary = XOR of the Gray code shifted right by every amount
    function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < W; k++) r = r ^ (g >> k);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: present requests, check grant, latency, result,
    // optional back-pressure hold, then consume and check return to idle.
    task automatic xact(input bit v0, input bit v1, input bit m0, input bit m1,
                        input logic [W-1:0] d0, input logic [W-1:0] d1,
                        input bit keep, input int hold, output logic [W-1:0] got);
        bit           g;
        bit           m;
        logic [W-1:0] d;
        logic [W-1:0] exp_data;
        logic [W-1:0] held;
        int           lat;
        int           exp_lat;

        bus.req0_valid = v0; bus.req0_mode = m0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_mode = m1; bus.req1_data = d1;
        g = (v0 && v1) ? ~last : (v0 ? 1'b0 : 1'b1);
        m = g ? m1 : m0;
        d = g ? d1 : d0;
        exp_data = m ? ref_g2b(d) : ref_b2g(d);
        exp_lat  = m ? W : 2;

        @(negedge clk);
        chk("req0_ready", 32'(bus.req0_ready), 32'(g == 1'b0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(g == 1'b1));
        @(posedge clk); #1;
        last = g;
        // operands change after acceptance; the result must not follow
        bus.req0_data = W'($urandom); bus.req0_mode = 1'($urandom);
        bus.req1_data = W'($urandom); bus.req1_mode = 1'($urandom);
        if (!keep) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
        end else begin
            bus.req0_mode = m0; bus.req0_data = d0;
            bus.req1_mode = m1; bus.req1_data = d1;
        end

        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
        chk("rsp_id", 32'(bus.rsp_id), 32'(g));
        got  = bus.rsp_data;
        held = bus.rsp_data;

        if (hold > 0) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_ready0", 32'(bus.req0_ready), 32'd0);
            chk("hold_ready1", 32'(bus.req1_ready), 32'd0);
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_data", 32'(bus.rsp_data), 32'(held));
            @(posedge clk); #1;
        end
        bus.req0_valid = keep ? v0 : 1'b0;
        bus.req1_valid = keep ? v1 : 1'b0;
        bus.rsp_ready  = 1'b1;
        @(negedge clk);
        if (keep) begin
            chk("resp_no_accept", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        $display("xact id=%0d mode=%0d data=%h result=%h lat=%0d", g, m, d, got, lat);
    endtask

    initial begin
        logic [W-1:0] r;
        logic [W-1:0] r2;
        bit           rv0;
        bit           rv1;
        int           seen;
        total = 0;
        bad   = 0;
        last  = 1'b1;
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_mode = 1'b0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_mode = 1'b0; bus.req1_data = '0;
        bus.rsp_ready  = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1/2: single-requester conversions
        xact(1, 0, 0, 0, 4'b1011, 4'b0000, 0, 0, r);
        chk("t1_value", 32'(r), 32'(4'b1110));
        xact(0, 1, 0, 1, 4'b0000, 4'b1110, 0, 0, r);
        chk("t2_value", 32'(r), 32'(4'b1011));
        xact(0, 1, 0, 1, 4'b0000, 4'b1000, 0, 0, r);
        chk("t2b_value", 32'(r), 32'(4'b1111));

        // 3: both requesting continuously, grants alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            xact(1, 1, 0, 0, 4'b0111, 4'b1100, 1, 0, r);
            chk("t3_value", 32'(r), (i % 2 == 0) ? 32'(4'b0100) : 32'(4'b1010));
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;

        // 4: back-pressure hold for 10 cycles
        xact(1, 0, 0, 0, 4'b1111, 4'b0000, 0, 10, r);
        chk("t4_value", 32'(r), 32'(4'b1000));

        // randomized traffic with random back-pressure
        for (int i = 0; i < 30; i++) begin
            rv0 = 1'($urandom);
            rv1 = 1'($urandom);
            if (!rv0 && !rv1) rv0 = 1'b1;
            xact(rv0, rv1, 1'($urandom), 1'($urandom), W'($urandom), W'($urandom),
                 0, $urandom_range(0, 3), r);
        end

        // 5: reset during Gray->binary with cnt=1
        bus.req1_valid = 1'b1; bus.req1_mode = 1'b1; bus.req1_data = 4'b1110;
        @(negedge clk);
        chk("t5_grant1", 32'(bus.req1_ready), 32'd1);
        @(posedge clk); #1;          // first G2B cycle (cnt=2)
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;          // second G2B cycle (cnt=1)
        chk("t5_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t5_rsp_data", 32'(bus.rsp_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        last  = 1'b1;
        seen  = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen++;
        end
        chk("t5_no_response", 32'(seen), 32'd0);
        xact(1, 1, 0, 0, 4'b0011, 4'b0101, 0, 0, r);
        chk("t5_after_value", 32'(r), 32'(4'b0010));

        // 6: exhaustive round trip through the DUT
        for (int x = 0; x < 16; x++) begin
            xact(1, 0, 0, 0, W'(x), '0, 0, 0, r);
            xact(0, 1, 0, 1, '0, r, 0, 0, r2);
            chk("t6_roundtrip", 32'(r2), 32'(x));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
